// File: rtl/pong_frame_rx.sv
// pong_frame_rx: game-state frame receiver with sync lock, checksum/range check and link health
// Ports: clock, reset (sync, active-high); rx_data/rx_valid byte stream in;
// ball_x/ball_y/opp_y latched fields; frame_valid/frame_error one-cycle pulses; link_up health.
// Define PONG_RX_MIRROR_EN to report ball_x as 1120 - x (player-2 node).
module pong_frame_rx #(
  parameter int BYTE_TIMEOUT = 1024,
  parameter int LINK_TIMEOUT = 4194304
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [10:0] opp_y,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        link_up
);
  localparam int BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int LW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [BW-1:0] B_LAST = BW'(BYTE_TIMEOUT - 1);
  localparam logic [LW-1:0] L_MAX = LW'(LINK_TIMEOUT);
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;
  state_t state, state_nxt;
  logic [2:0] idx;
  logic [7:0] sum;
  logic [47:0] pay;
  logic [BW-1:0] btmr;
  logic [LW-1:0] ltmr;
  logic expire, good, bad;
  logic [10:0] dx;
  // payload shifts in MSB-first: bx_hi bx_lo by_hi by_lo oy_hi oy_lo
`ifdef PONG_RX_MIRROR_EN
  assign dx = 11'd1120 - {pay[42:40], pay[39:32]};
`else
  assign dx = {pay[42:40], pay[39:32]};
`endif
  always_comb begin
    expire = state != HUNT && !rx_valid && btmr == B_LAST;
    good = state == CHECK && rx_valid && rx_data == sum
           && pay[47:43] == 5'd0 && pay[31:27] == 5'd0 && pay[15:11] == 5'd0;
    bad = expire || (state == CHECK && rx_valid && !good);
    state_nxt = state;
    case (state)
      HUNT:    state_nxt = rx_valid && rx_data == 8'hA5 ? PAYLOAD : HUNT;
      PAYLOAD: state_nxt = expire ? HUNT : (rx_valid && idx == 3'd5) ? CHECK : PAYLOAD;
      default: state_nxt = (expire || rx_valid) ? HUNT : CHECK;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) state <= HUNT;
    else state <= state_nxt;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      idx <= '0;
      sum <= '0;
      pay <= '0;
      btmr <= '0;
      ltmr <= '0;
      ball_x <= 11'd640;
      ball_y <= 11'd512;
      opp_y <= 11'd450;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      link_up <= 1'b0;
    end else begin
      idx <= (state == PAYLOAD && rx_valid) ? idx + 3'd1 : (state == HUNT) ? 3'd0 : idx;
      sum <= (state == PAYLOAD && rx_valid) ? sum ^ rx_data : (state == HUNT) ? 8'd0 : sum;
      if (state == PAYLOAD && rx_valid) pay <= {pay[39:0], rx_data};
      // a byte arriving on the would-expire cycle clears the timer instead of aborting
      btmr <= (state_nxt == HUNT || rx_valid) ? '0 : btmr + 1'b1;
      frame_valid <= good;
      frame_error <= bad;
      if (good) begin
        ball_x <= dx;
        ball_y <= {pay[26:24], pay[23:16]};
        opp_y <= {pay[10:8], pay[7:0]};
        ltmr <= '0;
        link_up <= 1'b1;
      end else if (ltmr != L_MAX) begin
        ltmr <= ltmr + 1'b1;
        if (ltmr == L_MAX - 1'b1) link_up <= 1'b0;
      end
    end
  end
endmodule

// File: doc/pong_frame_rx.md
# pong_frame_rx

Node-side receiver for the game-state link from the game server. Accepts a byte stream from the physical link's byte deserializer, locks onto frame sync, and decodes ball position and opponent paddle position. Checks each frame with an XOR checksum and a range check, then latches the decoded values for the node's renderer. Also tracks link health, so a stalled or corrupted link is visible to the node.

## Interface
Parameters:
- BYTE_TIMEOUT, 1024: max clocks between bytes inside a frame before abort.
- LINK_TIMEOUT, 4194304: clocks without a good frame before link_up drops.

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid this cycle; one byte per asserted cycle, no backpressure.
- ball_x  out  11  decoded ball x (optionally mirrored, see Configuration).
- ball_y  out  11  decoded ball y.
- opp_y  out  11  opponent paddle top y.
- frame_valid  out  1  one-cycle pulse: good frame latched.
- frame_error  out  1  one-cycle pulse: frame discarded.
- link_up  out  1  good frame received within the last LINK_TIMEOUT clocks.

## Operation
- Frame is 8 bytes: 0xA5 sync, then bx_hi, bx_lo, by_hi, by_lo, oy_hi, oy_lo, then chk.
- Each field is {hi[2:0], lo[7:0]}.
- chk is the XOR of the 6 payload bytes.
- FSM states:
  - HUNT: a byte equal to 0xA5 → PAYLOAD with idx=0; any other byte is dropped silently.
  - PAYLOAD: store the byte in slot idx and XOR it into the running checksum. idx 0..5; after idx 5 → CHECK. A 0xA5 byte here is data, not a resync.
  - CHECK: on the next byte, if it equals the running checksum and every hi byte has bits [7:3]=0, latch all three fields and pulse frame_valid. Otherwise pulse frame_error and leave outputs unchanged. Either way → HUNT.
- Byte timer: counts clocks in PAYLOAD/CHECK without rx_valid.
  - On reaching BYTE_TIMEOUT: pulse frame_error and go to HUNT; partial data is discarded.
  - If rx_valid arrives in the same cycle the timer would expire, the byte is accepted and the timer clears.
- Link timer:
  - Cleared on every frame_valid; saturates at LINK_TIMEOUT.
  - link_up=1 while timer < LINK_TIMEOUT and at least one good frame has been seen since reset.
- Back-to-back frames with no idle cycles are supported: a sync byte can follow chk on the very next cycle.

## Timing
- Reset values:
  - FSM=HUNT, idx=0, checksum=0, timers=0.
  - ball_x=640, ball_y=512, opp_y=450.
  - frame_valid=0, frame_error=0, link_up=0.
- Reset mid-frame discards the partial frame; the first byte after reset is treated in HUNT.
- Latency: chk sampled at edge N → ball_x/ball_y/opp_y/frame_valid updated at edge N (visible in the cycle after N). frame_valid/frame_error are high for exactly one cycle.
- All outputs are registered; no combinational path from rx_* to outputs.
- Arithmetic: fields are unsigned 11-bit; the mirror subtraction is 11-bit. Values above 1120 are not checked and wrap mod 2048.
- link_up falls at the edge where the link timer reaches LINK_TIMEOUT and rises at the frame_valid edge.

## Configuration
- PONG_RX_MIRROR_EN defined: ball_x = 1120 − decoded x, for the player-2 node, whose field is drawn mirrored.
- PONG_RX_MIRROR_EN undefined: ball_x = decoded x.
- The reset value of ball_x is 640 in both cases.
- ball_y and opp_y are never mirrored.

## Test plan
- Reset, then send A5 02 80 02 00 01 C2 43 → one frame_valid; ball_x=640, ball_y=512, opp_y=450; link_up=1.
- Send A5 02 D0 01 00 00 64 B7 without the macro → ball_x=720, ball_y=256, opp_y=100. With PONG_RX_MIRROR_EN → ball_x=400.
- Send the first frame with chk=0x44, then send a frame with bx_hi=0x08 and a correct chk → two frame_error pulses, outputs hold their prior values, no frame_valid.
- Send 3 garbage bytes 11 22 33, then a valid frame → no error pulses, one frame_valid. Send A5 followed by a 0xA5 payload byte → decoded as data.
- BYTE_TIMEOUT=16: send A5 02 and stop for 16 clocks → frame_error, FSM in HUNT; then a full valid frame is accepted.
- LINK_TIMEOUT=100: after a good frame, idle 100 clocks → link_up drops. Assert reset mid-frame → outputs return to reset values, and the next valid frame is decoded.
